sap_core: RTL and testbench

//  Parametrised SAP-class accumulator CPU. Successor to the fixed 8-bit, 4-op, 6-stage

---
 rtl/sap_pkg.sv | 37 +++
 rtl/sap_alu.sv | 28 ++
 rtl/sap_core.sv | 163 ++++++++++++++++
 tb/tb_sap_core.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared opcode, state and width definitions for the SAP accumulator CPU.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sap_pkg;

   // Narrowest opcode field that can hold every defined opcode
   localparam int OP_W_MIN = 4;

   // Opcode values; the core zero-extends these to its own opcode width
   localparam logic [3:0] OPC_LDA = 4'h0;
   localparam logic [3:0] OPC_ADD = 4'h1;
   localparam logic [3:0] OPC_SUB = 4'h2;
   localparam logic [3:0] OPC_STA = 4'h3;
   localparam logic [3:0] OPC_LDI = 4'h4;
   localparam logic [3:0] OPC_JMP = 4'h5;
   localparam logic [3:0] OPC_JC  = 4'h6;
   localparam logic [3:0] OPC_JZ  = 4'h7;
   localparam logic [3:0] OPC_OUT = 4'hE;
   localparam logic [3:0] OPC_HLT = 4'hF;

   // Control states: IDLE after reset, T0..T4 microcode steps, HALT after HLT
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T0   = 3'd1,
      ST_T1   = 3'd2,
      ST_T2   = 3'd3,
      ST_T3   = 3'd4,
      ST_T4   = 3'd5,
      ST_HALT = 3'd6
   } state_t;

   // True when the instruction word leaves room for a full opcode field
   function automatic bit op_w_ok(input int data_w, input int addr_w);
      return (data_w - addr_w) >= OP_W_MIN;
   endfunction

endpackage

// File: rtl/sap_alu.sv
// Add/subtract unit producing result, carry (no-borrow on subtract) and zero.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module sap_alu #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              sub_i,
   output logic [DATA_W-1:0] result_o,
   output logic              carry_o,
   output logic              zero_o
);

   logic [DATA_W-1:0] b_op;
   logic [DATA_W:0]   sum;

   // Subtract as a + ~b + 1 so the carry-out reads directly as "no borrow"
   always_comb begin
      b_op = sub_i ? ~b_i : b_i;
      sum  = {1'b0, a_i} + {1'b0, b_op} + {{DATA_W{1'b0}}, sub_i};
   end

   assign result_o = sum[DATA_W-1:0];
   assign carry_o  = sum[DATA_W];
   assign zero_o   = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_core.sv
// Parametrised SAP-class accumulator CPU with program RAM, flags and output port.
// Latency: 3 cycles LDI/JMP/Jcc/OUT/NOP/HLT, 4 cycles LDA/STA, 5 cycles ADD/SUB.
// Backpressure: none; run and prog_we are ignored while an instruction is in flight.
module sap_core
   import sap_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              busy,
   output logic              halted,
   output logic              flag_c,
   output logic              flag_z
);

   localparam int OP_W  = DATA_W - ADDR_W;
   localparam int DEPTH = 2 ** ADDR_W;

   if (!op_w_ok(DATA_W, ADDR_W)) begin : g_op_w_check
      $error("sap_core: DATA_W - ADDR_W must be at least 4");
   end

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] mar_q;
   logic [DATA_W-1:0] ir_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] out_q;
   logic              out_vld_q;
   logic              c_q;
   logic              z_q;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [OP_W-1:0]   opc;
   logic [ADDR_W-1:0] opnd;
   logic              idle_or_halt;
   logic              prog_wr;
   logic              sta_wr;
   logic [DATA_W-1:0] ram_rd;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;
   logic              alu_z;

   assign opc          = ir_q[DATA_W-1:ADDR_W];
   assign opnd         = ir_q[ADDR_W-1:0];
   assign idle_or_halt = (state_q == ST_IDLE) || (state_q == ST_HALT);
   assign prog_wr      = prog_we && idle_or_halt;
   assign sta_wr       = (state_q == ST_T3) && (opc == OP_W'(OPC_STA));
   assign ram_rd       = mem_q[mar_q];

   // RAM write port: loader and STA live in disjoint states; no reset so contents survive rst_n
   always_ff @(posedge clk) begin
      if (prog_wr) begin
         mem_q[prog_addr] <= prog_data;
      end else if (sta_wr) begin
         mem_q[mar_q] <= a_q;
      end
   end

   sap_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .sub_i    (opc == OP_W'(OPC_SUB)),
      .result_o (alu_res),
      .carry_o  (alu_c),
      .zero_o   (alu_z)
   );

   // Control FSM and datapath registers; each instruction returns to T0 as soon as it is done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         mar_q     <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
         c_q       <= 1'b0;
         z_q       <= 1'b0;
      end else begin
         out_vld_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_HALT: begin
               if (run) begin
                  pc_q    <= '0;
                  a_q     <= '0;
                  b_q     <= '0;
                  c_q     <= 1'b0;
                  z_q     <= 1'b0;
                  out_q   <= '0;
                  state_q <= ST_T0;
               end
            end
            ST_T0: begin
               mar_q   <= pc_q;
               state_q <= ST_T1;
            end
            ST_T1: begin
               ir_q    <= ram_rd;
               pc_q    <= pc_q + ADDR_W'(1);
               state_q <= ST_T2;
            end
            ST_T2: begin
               state_q <= ST_T0;
               case (opc)
                  OP_W'(OPC_LDA), OP_W'(OPC_ADD), OP_W'(OPC_SUB), OP_W'(OPC_STA): begin
                     mar_q   <= opnd;
                     state_q <= ST_T3;
                  end
                  OP_W'(OPC_LDI): a_q <= {{OP_W{1'b0}}, opnd};
                  OP_W'(OPC_JMP): pc_q <= opnd;
                  OP_W'(OPC_JC):  if (c_q) pc_q <= opnd;
                  OP_W'(OPC_JZ):  if (z_q) pc_q <= opnd;
                  OP_W'(OPC_OUT): begin
                     out_q     <= a_q;
                     out_vld_q <= 1'b1;
                  end
                  OP_W'(OPC_HLT): state_q <= ST_HALT;
                  default: ;
               endcase
            end
            ST_T3: begin
               state_q <= ST_T0;
               if (opc == OP_W'(OPC_LDA)) begin
                  a_q <= ram_rd;
               end else if (opc == OP_W'(OPC_ADD) || opc == OP_W'(OPC_SUB)) begin
                  b_q     <= ram_rd;
                  state_q <= ST_T4;
               end
            end
            ST_T4: begin
               a_q     <= alu_res;
               c_q     <= alu_c;
               z_q     <= alu_z;
               state_q <= ST_T0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_data  = out_q;
   assign out_valid = out_vld_q;
   assign busy      = (state_q == ST_T0) || (state_q == ST_T1) || (state_q == ST_T2) ||
                      (state_q == ST_T3) || (state_q == ST_T4);
   assign halted    = (state_q == ST_HALT);
   assign flag_c    = c_q;
   assign flag_z    = z_q;

endmodule

// File: tb/tb_sap_core.sv
// Directed bench for sap_core: program loads, arithmetic/flags, jumps, wrap, reset abort, busy guards.
// Latency: checks exact halt cycle counts per program.
// Backpressure: n/a.
module tb_sap_core;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [7:0] prog_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       busy;
   logic       halted;
   logic       flag_c;
   logic       flag_z;

   int n_checks;
   int n_fail;

   // out_valid capture log, written only by the monitor below
   logic [5:0] ov_cnt;
   logic [7:0] cap_d [64];
   logic       cap_c [64];
   logic       cap_z [64];

   sap_core #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .busy      (busy),
      .halted    (halted),
      .flag_c    (flag_c),
      .flag_z    (flag_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial ov_cnt = '0;
   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         cap_d[ov_cnt] = out_data;
         cap_c[ov_cnt] = flag_c;
         cap_z[ov_cnt] = flag_z;
         ov_cnt = ov_cnt + 6'd1;
      end
   end

   task automatic prog(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic start();
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic wait_halt(input int budget, output int cyc);
      cyc = 0;
      while (halted !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic load_prog1();
      prog(4'h0, 8'h0D); prog(4'h1, 8'h1E); prog(4'h2, 8'h2F);
      prog(4'h3, 8'hE0); prog(4'h4, 8'hF0);
      prog(4'hD, 8'h03); prog(4'hE, 8'h04); prog(4'hF, 8'h02);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      #12;
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
      n_checks++; if ({flag_c, flag_z} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {flag_c, flag_z}); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_program();
      int cyc; logic [5:0] base;
      load_prog1();
      base = ov_cnt;
      start();
      wait_halt(200, cyc);
      n_checks++; if (cyc !== 20) begin n_fail++; $display("FAIL t1_halt_cycles got %0d want 20", cyc); end
      n_checks++; if (ov_cnt - base !== 6'd1) begin n_fail++; $display("FAIL t1_pulses got %0d want 1", ov_cnt - base); end
      n_checks++; if (cap_d[base] !== 8'h05) begin n_fail++; $display("FAIL t1_out got %h want 05", cap_d[base]); end
      n_checks++; if (out_data !== 8'h05) begin n_fail++; $display("FAIL t1_out_hold got %h want 05", out_data); end
      n_checks++; if ({flag_c, flag_z} !== 2'b10) begin n_fail++; $display("FAIL t1_flags got %b want 10", {flag_c, flag_z}); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_in_halt got %b want 0", busy); end
   endtask

   task automatic test_add_sub_flags();
      int cyc; logic [5:0] base;
      prog(4'h0, 8'h0F); prog(4'h1, 8'h1E); prog(4'h2, 8'hE0);
      prog(4'h3, 8'h2E); prog(4'h4, 8'hE0); prog(4'h5, 8'hF0);
      prog(4'hE, 8'h01); prog(4'hF, 8'hFF);
      base = ov_cnt;
      start();
      wait_halt(200, cyc);
      n_checks++; if (cyc !== 23) begin n_fail++; $display("FAIL t2_halt_cycles got %0d want 23", cyc); end
      n_checks++; if (ov_cnt - base !== 6'd2) begin n_fail++; $display("FAIL t2_pulses got %0d want 2", ov_cnt - base); end
      n_checks++; if ({cap_d[base], cap_c[base], cap_z[base]} !== {8'h00, 1'b1, 1'b1})
         begin n_fail++; $display("FAIL t2_add got %h c%b z%b want 00 c1 z1", cap_d[base], cap_c[base], cap_z[base]); end
      n_checks++; if ({cap_d[base+1], cap_c[base+1], cap_z[base+1]} !== {8'hFF, 1'b0, 1'b0})
         begin n_fail++; $display("FAIL t2_sub got %h c%b z%b want FF c0 z0", cap_d[base+1], cap_c[base+1], cap_z[base+1]); end
   endtask

   task automatic test_sta_ldi();
      int cyc; logic [5:0] base;
      prog(4'h9, 8'h00);
      prog(4'h0, 8'h47); prog(4'h1, 8'h39); prog(4'h2, 8'h09);
      prog(4'h3, 8'hE0); prog(4'h4, 8'hF0);
      base = ov_cnt;
      start();
      wait_halt(200, cyc);
      n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL t3_halt_cycles got %0d want 17", cyc); end
      n_checks++; if (ov_cnt - base !== 6'd1 || cap_d[base] !== 8'h07)
         begin n_fail++; $display("FAIL t3_sta_lda got %h x%0d want 07 x1", cap_d[base], ov_cnt - base); end
      // Loader writes while halted
      prog(4'h9, 8'h5A); prog(4'h0, 8'h09); prog(4'h1, 8'hE0); prog(4'h2, 8'hF0);
      base = ov_cnt;
      start();
      wait_halt(200, cyc);
      n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL t3_reload_cycles got %0d want 10", cyc); end
      n_checks++; if (cap_d[base] !== 8'h5A) begin n_fail++; $display("FAIL t3_prog_after_halt got %h want 5A", cap_d[base]); end
   endtask

   task automatic test_jumps_wrap();
      int cyc; logic [5:0] base;
      prog(4'h0, 8'h74); prog(4'h1, 8'h65); prog(4'h2, 8'h0A); prog(4'h3, 8'h2A);
      prog(4'h4, 8'h76); prog(4'h5, 8'hE0); prog(4'h6, 8'h68); prog(4'h7, 8'hE0);
      prog(4'h8, 8'hE0); prog(4'h9, 8'hF0); prog(4'hA, 8'h03);
      base = ov_cnt;
      start();
      wait_halt(200, cyc);
      n_checks++; if (cyc !== 27) begin n_fail++; $display("FAIL t4_jcc_cycles got %0d want 27", cyc); end
      n_checks++; if (ov_cnt - base !== 6'd1) begin n_fail++; $display("FAIL t4_jcc_pulses got %0d want 1", ov_cnt - base); end
      n_checks++; if ({cap_d[base], cap_c[base], cap_z[base]} !== {8'h00, 1'b1, 1'b1})
         begin n_fail++; $display("FAIL t4_jcc_out got %h c%b z%b want 00 c1 z1", cap_d[base], cap_c[base], cap_z[base]); end
      // Self-modify RAM[0] to HLT, then JMP F -> NOP -> wrap to 0
      prog(4'h0, 8'h0E); prog(4'h1, 8'h30); prog(4'h2, 8'h5F);
      prog(4'hE, 8'hF0); prog(4'hF, 8'h80);
      base = ov_cnt;
      start();
      wait_halt(200, cyc);
      n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL t4_wrap_cycles got %0d want 17", cyc); end
      n_checks++; if (ov_cnt !== base) begin n_fail++; $display("FAIL t4_wrap_pulses got %0d want 0", ov_cnt - base); end
      start();
      wait_halt(200, cyc);
      n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL t4_rerun_cycles got %0d want 3", cyc); end
      // run held high across HLT restarts on the next cycle
      @(negedge clk); run = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t4_hold_start got %b want 1", busy); end
      repeat (3) @(negedge clk);
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL t4_hold_halt got %b want 1", halted); end
      @(negedge clk);
      n_checks++; if ({busy, halted} !== 2'b10) begin n_fail++; $display("FAIL t4_hold_restart got %b want 10", {busy, halted}); end
      run = 1'b0;
      wait_halt(200, cyc);
      n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL t4_hold_cycles got %0d want 3", cyc); end
   endtask

   task automatic test_reset_abort();
      int cyc; logic [5:0] base;
      load_prog1();
      start();
      repeat (7) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t5_busy_mid got %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({busy, halted, out_valid, flag_c, flag_z} !== 5'b00000)
         begin n_fail++; $display("FAIL t5_async_ctl got %b want 00000", {busy, halted, out_valid, flag_c, flag_z}); end
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL t5_async_out got %h want 00", out_data); end
      @(negedge clk); rst_n = 1'b1;
      base = ov_cnt;
      start();
      wait_halt(200, cyc);
      n_checks++; if (cyc !== 20) begin n_fail++; $display("FAIL t5_rerun_cycles got %0d want 20", cyc); end
      n_checks++; if (ov_cnt - base !== 6'd1 || cap_d[base] !== 8'h05)
         begin n_fail++; $display("FAIL t5_rerun_out got %h x%0d want 05 x1", cap_d[base], ov_cnt - base); end
   endtask

   task automatic test_busy_guards();
      int cyc; logic [5:0] base;
      base = ov_cnt;
      start();
      repeat (3) @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'hD; prog_data = 8'h7F; run = 1'b1;
      @(negedge clk);
      prog_we = 1'b0; run = 1'b0;
      wait_halt(200, cyc);
      n_checks++; if (cyc + 4 !== 20) begin n_fail++; $display("FAIL t6_busy_cycles got %0d want 20", cyc + 4); end
      n_checks++; if (ov_cnt - base !== 6'd1 || cap_d[base] !== 8'h05)
         begin n_fail++; $display("FAIL t6_busy_ignored got %h x%0d want 05 x1", cap_d[base], ov_cnt - base); end
      // Write and run in the same halted cycle: fetch must see LDI B at address 0
      base = ov_cnt;
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'h4B; run = 1'b1;
      @(negedge clk);
      prog_we = 1'b0; run = 1'b0;
      wait_halt(200, cyc);
      n_checks++; if (cyc !== 19) begin n_fail++; $display("FAIL t6_same_cycle_cycles got %0d want 19", cyc); end
      n_checks++; if ({cap_d[base], cap_c[base], cap_z[base]} !== {8'h0D, 1'b1, 1'b0})
         begin n_fail++; $display("FAIL t6_same_cycle_out got %h c%b z%b want 0D c1 z0", cap_d[base], cap_c[base], cap_z[base]); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_basic_program();
      test_add_sub_flags();
      test_sta_ldi();
      test_jumps_wrap();
      test_reset_abort();
      test_busy_guards();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
